// File: rtl/fdivider.sv
// IEEE-754 single-precision divider; restoring divide, ~110-160 cycles per result. Define FDIV_DENORM_EN for
// denormal inputs/results, otherwise they flush to signed zero. No backpressure: input_stb is only taken in idle.
module fdivider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        input_stb,
    output logic        busy,
    output logic [31:0] output_z,
    output logic        output_z_stb
);

    typedef enum logic [3:0] {
        S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B, S_DIV0, S_DIV1,
        S_DIV2, S_DIV3, S_NORM1, S_NORM2, S_ROUND, S_PACK, S_PUT_Z
    } state_t;

    localparam logic signed [9:0] E_ZERO  = -10'sd127;
    localparam logic signed [9:0] E_INF   = 10'sd128;
    localparam logic signed [9:0] E_MIN   = -10'sd126;
    localparam logic signed [9:0] E_MAX   = 10'sd127;
    localparam logic signed [9:0] E_FLOOR = -10'sd151;
    localparam logic [31:0]       QNAN    = 32'hFFC00000;

    state_t             state_q, state_d;
    logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
    logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic               guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
    logic [50:0]        dividend_q, dividend_d, divisor_q, divisor_d;
    logic [50:0]        quotient_q, quotient_d, remainder_q, remainder_d;
    logic [5:0]         count_q, count_d;
    logic [31:0]        res_q, res_d, z_out_q, z_out_d;
    logic               z_stb_q, z_stb_d, busy_q, busy_d;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_hit, sgn;

    assign sgn   = a_s_q ^ b_s_q;
    assign a_nan = (a_e_q == E_INF) && (a_m_q != 24'd0);
    assign b_nan = (b_e_q == E_INF) && (b_m_q != 24'd0);
    assign a_inf = (a_e_q == E_INF) && (a_m_q == 24'd0);
    assign b_inf = (b_e_q == E_INF) && (b_m_q == 24'd0);
`ifdef FDIV_DENORM_EN
    assign a_zero = (a_e_q == E_ZERO) && (a_m_q == 24'd0);
    assign b_zero = (b_e_q == E_ZERO) && (b_m_q == 24'd0);
`else
    assign a_zero = (a_e_q == E_ZERO);
    assign b_zero = (b_e_q == E_ZERO);
`endif
    assign special_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign busy         = busy_q;
    assign output_z     = z_out_q;
    assign output_z_stb = z_stb_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (input_stb) state_d = S_UNPACK;
            S_UNPACK:  state_d = S_SPECIAL;
            S_SPECIAL: state_d = special_hit ? S_PUT_Z : S_NORM_A;
            S_NORM_A:  if (a_m_q[23]) state_d = S_NORM_B;
            S_NORM_B:  if (b_m_q[23]) state_d = S_DIV0;
            S_DIV0:    state_d = S_DIV1;
            S_DIV1:    state_d = S_DIV2;
            S_DIV2:    state_d = (count_q == 6'd49) ? S_DIV3 : S_DIV1;
            S_DIV3:    state_d = S_NORM1;
            S_NORM1: if (z_m_q[23]) begin
`ifdef FDIV_DENORM_EN
                state_d = S_NORM2;
`else
                state_d = (z_e_q < E_MIN) ? S_PUT_Z : S_ROUND;
`endif
            end
            S_NORM2:   if (z_e_q >= E_MIN) state_d = S_ROUND;
            S_ROUND:   state_d = S_PACK;
            S_PACK:    state_d = S_PUT_Z;
            S_PUT_Z:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_a_d = op_a_q;  op_b_d = op_b_q;
        a_m_d = a_m_q;  a_e_d = a_e_q;  a_s_d = a_s_q;
        b_m_d = b_m_q;  b_e_d = b_e_q;  b_s_d = b_s_q;
        z_m_d = z_m_q;  z_e_d = z_e_q;  z_s_d = z_s_q;
        guard_d = guard_q;  round_bit_d = round_bit_q;  sticky_d = sticky_q;
        dividend_d = dividend_q;  divisor_d = divisor_q;
        quotient_d = quotient_q;  remainder_d = remainder_q;
        count_d = count_q;  res_d = res_q;  z_out_d = z_out_q;
        z_stb_d = 1'b0;  busy_d = busy_q;
        case (state_q)
            S_IDLE: if (input_stb) begin
                op_a_d = input_a;
                op_b_d = input_b;
                busy_d = 1'b1;
            end
            S_UNPACK: begin
                a_m_d = {1'b0, op_a_q[22:0]};
                b_m_d = {1'b0, op_b_q[22:0]};
                a_e_d = $signed({2'b00, op_a_q[30:23]}) - 10'sd127;
                b_e_d = $signed({2'b00, op_b_q[30:23]}) - 10'sd127;
                a_s_d = op_a_q[31];
                b_s_d = op_b_q[31];
            end
            S_SPECIAL: begin
                if (a_nan || b_nan)           res_d = QNAN;
                else if (a_inf)               res_d = b_inf ? QNAN : {sgn, 8'hFF, 23'd0};
                else if (b_inf)               res_d = {sgn, 31'd0};
                else if (a_zero && b_zero)    res_d = QNAN;
                else if (b_zero)              res_d = {sgn, 8'hFF, 23'd0};
                else if (a_zero)              res_d = {sgn, 31'd0};
                else begin
                    // Denormals carry the minimum exponent and no hidden bit.
                    if (a_e_q == E_ZERO) a_e_d = E_MIN;
                    else                 a_m_d[23] = 1'b1;
                    if (b_e_q == E_ZERO) b_e_d = E_MIN;
                    else                 b_m_d[23] = 1'b1;
                end
            end
            S_NORM_A: if (!a_m_q[23]) begin
                a_m_d = a_m_q << 1;
                a_e_d = a_e_q - 10'sd1;
            end
            S_NORM_B: if (!b_m_q[23]) begin
                b_m_d = b_m_q << 1;
                b_e_d = b_e_q - 10'sd1;
            end
            S_DIV0: begin
                z_s_d       = sgn;
                z_e_d       = a_e_q - b_e_q;
                dividend_d  = {a_m_q, 27'd0};
                divisor_d   = {27'd0, b_m_q};
                quotient_d  = '0;
                remainder_d = '0;
                count_d     = '0;
            end
            S_DIV1: begin
                quotient_d  = quotient_q << 1;
                remainder_d = {remainder_q[49:0], dividend_q[50]};
                dividend_d  = dividend_q << 1;
            end
            S_DIV2: begin
                if (remainder_q >= divisor_q) begin
                    quotient_d  = quotient_q | 51'd1;
                    remainder_d = remainder_q - divisor_q;
                end
                count_d = count_q + 6'd1;
            end
            S_DIV3: begin
                z_m_d       = quotient_q[26:3];
                guard_d     = quotient_q[2];
                round_bit_d = quotient_q[1];
                sticky_d    = quotient_q[0] | (|remainder_q);
            end
            S_NORM1: begin
                if (!z_m_q[23]) begin
                    z_m_d       = {z_m_q[22:0], guard_q};
                    guard_d     = round_bit_q;
                    round_bit_d = 1'b0;
                    z_e_d       = z_e_q - 10'sd1;
                end else if (z_e_q < E_MIN) begin
                    res_d = {z_s_q, 31'd0};
                end
            end
            S_NORM2: begin
                // Far below the denormal range everything lands in sticky; skip the long shift.
                if (z_e_q < E_FLOOR) begin
                    sticky_d    = sticky_q | round_bit_q | guard_q | (|z_m_q);
                    z_m_d       = '0;
                    guard_d     = 1'b0;
                    round_bit_d = 1'b0;
                    z_e_d       = E_MIN;
                end else if (z_e_q < E_MIN) begin
                    z_m_d       = z_m_q >> 1;
                    guard_d     = z_m_q[0];
                    round_bit_d = guard_q;
                    sticky_d    = sticky_q | round_bit_q;
                    z_e_d       = z_e_q + 10'sd1;
                end
            end
            S_ROUND: if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
                z_m_d = z_m_q + 24'd1;
                if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
            end
            S_PACK: begin
                res_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
                if ((z_e_q == E_MIN) && !z_m_q[23]) res_d[30:23] = 8'd0;
                if (z_e_q > E_MAX)                  res_d = {z_s_q, 8'hFF, 23'd0};
            end
            S_PUT_Z: begin
                z_out_d = res_q;
                z_stb_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q <= '0;  op_b_q <= '0;
            a_m_q <= '0;  a_e_q <= '0;  a_s_q <= 1'b0;
            b_m_q <= '0;  b_e_q <= '0;  b_s_q <= 1'b0;
            z_m_q <= '0;  z_e_q <= '0;  z_s_q <= 1'b0;
            guard_q <= 1'b0;  round_bit_q <= 1'b0;  sticky_q <= 1'b0;
            dividend_q <= '0;  divisor_q <= '0;  quotient_q <= '0;  remainder_q <= '0;
            count_q <= '0;  res_q <= '0;  z_out_q <= '0;
            z_stb_q <= 1'b0;  busy_q <= 1'b0;
        end else begin
            op_a_q <= op_a_d;  op_b_q <= op_b_d;
            a_m_q <= a_m_d;  a_e_q <= a_e_d;  a_s_q <= a_s_d;
            b_m_q <= b_m_d;  b_e_q <= b_e_d;  b_s_q <= b_s_d;
            z_m_q <= z_m_d;  z_e_q <= z_e_d;  z_s_q <= z_s_d;
            guard_q <= guard_d;  round_bit_q <= round_bit_d;  sticky_q <= sticky_d;
            dividend_q <= dividend_d;  divisor_q <= divisor_d;
            quotient_q <= quotient_d;  remainder_q <= remainder_d;
            count_q <= count_d;  res_q <= res_d;  z_out_q <= z_out_d;
            z_stb_q <= z_stb_d;  busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_fdivider.sv
// Directed-vector bench for fdivider: special cases, rounding, overflow, denormal flush and mid-operation reset.
module tb_fdivider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] input_a, input_b;
    logic        input_stb;
    logic        busy;
    logic [31:0] output_z;
    logic        output_z_stb;

    int n_checks = 0;
    int n_fail   = 0;

    fdivider dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_b      (input_b),
        .input_stb    (input_stb),
        .busy         (busy),
        .output_z     (output_z),
        .output_z_stb (output_z_stb)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // hold=1 keeps input_stb high with different operands while busy; they must be ignored.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit hold);
        int cyc;
        @(negedge clk);
        input_a   = a;
        input_b   = b;
        input_stb = 1'b1;
        @(negedge clk);
        chk1({tag, "/busy"}, busy, 1'b1);
        if (hold) begin
            input_a = 32'h3F800000;
            input_b = 32'h3F800000;
        end else begin
            input_stb = 1'b0;
        end
        cyc = 1;
        while (output_z_stb !== 1'b1 && cyc < 250) begin
            @(negedge clk);
            cyc++;
        end
        input_stb = 1'b0;
        chk1({tag, "/latency"}, cyc <= 180, 1'b1);
        chk32({tag, "/z"}, output_z, exp);
        @(negedge clk);
        chk1({tag, "/one_pulse"}, output_z_stb, 1'b0);
        chk1({tag, "/idle"}, busy, 1'b0);
        chk32({tag, "/z_hold"}, output_z, exp);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        input_stb = 1'b0;
        input_a   = '0;
        input_b   = '0;
        repeat (3) @(negedge clk);
        chk1("reset/busy", busy, 1'b0);
        chk1("reset/stb", output_z_stb, 1'b0);
        chk32("reset/z", output_z, 32'h00000000);
        rst = 1'b0;

        run_div("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        run_div("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
        run_div("2/3",       32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0);
        run_div("1/1",       32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
        run_div("1/0",       32'h3F800000, 32'h00000000, 32'h7F800000, 1'b0);
        run_div("-1/0",      32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0);
        run_div("0/0",       32'h00000000, 32'h00000000, 32'hFFC00000, 1'b0);
        run_div("0/-2",      32'h00000000, 32'hC0000000, 32'h80000000, 1'b0);
        run_div("inf/inf",   32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0);
        run_div("inf/-2",    32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0);
        run_div("1/inf",     32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0);
        run_div("nan/1",     32'h7FC00000, 32'h3F800000, 32'hFFC00000, 1'b0);
        run_div("-8/0.5",    32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b1);
        run_div("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0);
`ifdef FDIV_DENORM_EN
        run_div("min/2",     32'h00800000, 32'h40000000, 32'h00400000, 1'b0);
        run_div("denorm/2",  32'h00400000, 32'h40000000, 32'h00200000, 1'b0);
`else
        run_div("min/2",     32'h00800000, 32'h40000000, 32'h00000000, 1'b0);
        run_div("denorm/2",  32'h00400000, 32'h40000000, 32'h00000000, 1'b0);
`endif

        // Reset while in divide_1 with input_stb still asserted.
        @(negedge clk);
        input_a   = 32'h40C00000;
        input_b   = 32'h40000000;
        input_stb = 1'b1;
        repeat (10) @(negedge clk);
        chk1("midrst/busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst/busy", busy, 1'b0);
        chk1("midrst/stb", output_z_stb, 1'b0);
        chk32("midrst/z", output_z, 32'h00000000);
        @(negedge clk);
        chk1("midrst/rst_over_stb", busy, 1'b0);
        input_stb = 1'b0;
        rst       = 1'b0;
        pulses    = 0;
        repeat (150) begin
            @(negedge clk);
            if (output_z_stb === 1'b1) pulses++;
        end
        chk32("midrst/no_pulse", 32'(pulses), 32'd0);
        chk1("midrst/still_idle", busy, 1'b0);
        run_div("6/2_after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
